// File: rtl/fast_stage_pipe.sv
// fast_stage_pipe: STAGES cascaded two-entry skid buffers carrying one packet beat per transfer.
// Optional stall/beat performance counters are built when FAST_STAGE_PERF_CNT_EN is defined.

`ifndef FAST_LENGTH_BITS
`define FAST_LENGTH_BITS 8
`endif
`ifndef FAST_MESSAGE_BITS
`define FAST_MESSAGE_BITS 16
`endif
`ifndef PACKET_HEAD_DATA_BITS
`define PACKET_HEAD_DATA_BITS 8
`endif
`ifndef packet_ETX_data_bits
`define packet_ETX_data_bits 8
`endif

module fast_stage_skid #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         up_valid,
   output logic         up_ready,
   input  logic [W-1:0] up_data,
   output logic         dn_valid,
   input  logic         dn_ready,
   output logic [W-1:0] dn_data
);

   logic         main_v;
   logic         skid_v;
   logic         rdy_q;
   logic [W-1:0] main_d;
   logic [W-1:0] skid_d;

   // rdy_q is the registered "skid empty" flag; it is the only ready seen upstream,
   // so dn_ready never reaches up_ready combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         main_d <= '0;
         skid_d <= '0;
         rdy_q  <= 1'b1;
      end else if (flush) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         rdy_q  <= 1'b0;
      end else if (rdy_q) begin
         if (!main_v || dn_ready) begin
            main_v <= up_valid;
            if (up_valid) begin
               main_d <= up_data;
            end
         end else if (up_valid) begin
            skid_v <= 1'b1;
            skid_d <= up_data;
            rdy_q  <= 1'b0;
         end
      end else if (skid_v) begin
         if (dn_ready) begin
            main_d <= skid_d;
            main_v <= 1'b1;
            skid_v <= 1'b0;
            rdy_q  <= 1'b1;
         end
      end else begin
         // recovering from a flush: nothing buffered, reopen next cycle
         rdy_q <= 1'b1;
      end
   end

   assign up_ready = rdy_q;
   assign dn_valid = main_v;
   assign dn_data  = main_d;

endmodule

module fast_stage_pipe #(
   parameter int CH     = 3,
   parameter int LEN_W  = `FAST_LENGTH_BITS,
   parameter int MSG_W  = `FAST_MESSAGE_BITS,
   parameter int HEAD_W = `PACKET_HEAD_DATA_BITS,
   parameter int ETX_W  = `packet_ETX_data_bits,
   parameter int STAGES = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CH-1:0]       in_ch_en,
   input  logic [HEAD_W-1:0]   in_head,
   input  logic [CH*LEN_W-1:0] in_len,
   input  logic [CH*MSG_W-1:0] in_msg,
   input  logic [ETX_W-1:0]    in_etx,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CH-1:0]       out_ch_en,
   output logic [HEAD_W-1:0]   out_head,
   output logic [CH*LEN_W-1:0] out_len,
   output logic [CH*MSG_W-1:0] out_msg,
   output logic [ETX_W-1:0]    out_etx,
   output logic [31:0]         stall_cnt,
   output logic [31:0]         beat_cnt
);

   localparam int BW = CH + HEAD_W + CH*LEN_W + CH*MSG_W + ETX_W;

   logic [CH*LEN_W-1:0]      len_m;
   logic [CH*MSG_W-1:0]      msg_m;
   logic [BW-1:0]            in_beat;
   logic [STAGES:0]          v_chain;
   logic [STAGES:0]          r_chain;
   logic [STAGES:0][BW-1:0]  d_chain;

   // disabled channels are zeroed once at capture so every stage carries clean data
   always_comb begin
      len_m = '0;
      msg_m = '0;
      for (int i = 0; i < CH; i++) begin
         if (in_ch_en[i]) begin
            len_m[i*LEN_W +: LEN_W] = in_len[i*LEN_W +: LEN_W];
            msg_m[i*MSG_W +: MSG_W] = in_msg[i*MSG_W +: MSG_W];
         end
      end
   end

   assign in_beat         = {in_ch_en, in_head, len_m, msg_m, in_etx};
   assign v_chain[0]      = in_valid;
   assign d_chain[0]      = in_beat;
   assign r_chain[STAGES] = out_ready;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      fast_stage_skid #(.W(BW)) u_stage (
         .clk      (clk),
         .rst      (rst),
         .flush    (flush),
         .up_valid (v_chain[s]),
         .up_ready (r_chain[s]),
         .up_data  (d_chain[s]),
         .dn_valid (v_chain[s+1]),
         .dn_ready (r_chain[s+1]),
         .dn_data  (d_chain[s+1])
      );
   end

   // flush and reset close the input immediately, before their edge takes effect
   assign in_ready  = r_chain[0] & ~flush & ~rst;
   assign out_valid = v_chain[STAGES] & ~rst;
   assign {out_ch_en, out_head, out_len, out_msg, out_etx} = d_chain[STAGES];

`ifdef FAST_STAGE_PERF_CNT_EN
   logic [31:0] stall_q;
   logic [31:0] beat_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         beat_q  <= '0;
      end else begin
         if (out_valid && !out_ready) begin
            stall_q <= stall_q + 32'd1;
         end
         if (out_valid && out_ready) begin
            beat_q <= beat_q + 32'd1;
         end
      end
   end

   assign stall_cnt = stall_q;
   assign beat_cnt  = beat_q;
`else
   assign stall_cnt = '0;
   assign beat_cnt  = '0;
`endif

endmodule

// File: tb/tb_fast_stage_pipe.sv
// Directed bench for fast_stage_pipe: a one-stage and a two-stage instance share the input side.
module tb_fast_stage_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [2:0]  in_ch_en = '0;
   logic [7:0]  in_head = '0;
   logic [23:0] in_len = '0;
   logic [47:0] in_msg = '0;
   logic [7:0]  in_etx = '0;

   logic        o1_in_ready, o1_out_valid;
   logic [2:0]  o1_ch_en;
   logic [7:0]  o1_head, o1_etx;
   logic [23:0] o1_len;
   logic [47:0] o1_msg;
   logic [31:0] o1_stall, o1_beat;

   logic        o2_in_ready, o2_out_valid;
   logic [2:0]  o2_ch_en;
   logic [7:0]  o2_head, o2_etx;
   logic [23:0] o2_len;
   logic [47:0] o2_msg;
   logic [31:0] o2_stall, o2_beat;

   int total = 0;
   int bad = 0;

`ifdef FAST_STAGE_PERF_CNT_EN
   localparam int EXP_STALL = 7;
   localparam int EXP_BEAT  = 4;
`else
   localparam int EXP_STALL = 0;
   localparam int EXP_BEAT  = 0;
`endif

   always #5 clk = ~clk;

   fast_stage_pipe #(.CH(3), .LEN_W(8), .MSG_W(16), .HEAD_W(8), .ETX_W(8), .STAGES(1)) u1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o1_in_ready),
      .in_ch_en(in_ch_en), .in_head(in_head), .in_len(in_len), .in_msg(in_msg), .in_etx(in_etx),
      .out_valid(o1_out_valid), .out_ready(out_ready), .out_ch_en(o1_ch_en), .out_head(o1_head),
      .out_len(o1_len), .out_msg(o1_msg), .out_etx(o1_etx), .stall_cnt(o1_stall), .beat_cnt(o1_beat)
   );

   fast_stage_pipe #(.CH(3), .LEN_W(8), .MSG_W(16), .HEAD_W(8), .ETX_W(8), .STAGES(2)) u2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o2_in_ready),
      .in_ch_en(in_ch_en), .in_head(in_head), .in_len(in_len), .in_msg(in_msg), .in_etx(in_etx),
      .out_valid(o2_out_valid), .out_ready(out_ready), .out_ch_en(o2_ch_en), .out_head(o2_head),
      .out_len(o2_len), .out_msg(o2_msg), .out_etx(o2_etx), .stall_cnt(o2_stall), .beat_cnt(o2_beat)
   );

   typedef struct {
      logic [2:0]  ch_en;
      logic [23:0] len;
      logic [47:0] msg;
      logic [23:0] exp_len;
      logic [47:0] exp_msg;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic probe();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int acc;
      int seen;
      logic took;

      vecs[0] = '{3'b101, 24'hFFFFFF, 48'hFFFF_FFFF_FFFF, 24'hFF00FF, 48'hFFFF_0000_FFFF};
      vecs[1] = '{3'b000, 24'hFFFFFF, 48'hFFFF_FFFF_FFFF, 24'h000000, 48'h0000_0000_0000};
      vecs[2] = '{3'b111, 24'h123456, 48'hAAAA_5555_1234, 24'h123456, 48'hAAAA_5555_1234};
      vecs[3] = '{3'b010, 24'hABCDEF, 48'h1111_2222_3333, 24'h00CD00, 48'h0000_2222_0000};
      vecs[4] = '{3'b001, 24'h010203, 48'h9999_8888_7777, 24'h000003, 48'h0000_0000_7777};
      vecs[5] = '{3'b110, 24'h776655, 48'hDEAD_BEEF_CAFE, 24'h776600, 48'hDEAD_BEEF_0000};

      // reset state
      probe();
      chk("rst_out_valid", 64'(o1_out_valid), 64'd0);
      chk("rst_in_ready", 64'(o1_in_ready), 64'd0);
      chk("rst_head_cleared", 64'(o1_head), 64'd0);
      chk("rst_stall_cnt", 64'(o2_stall), 64'd0);
      tick();
      rst = 1'b0;
      probe();
      chk("post_rst_ready1", 64'(o1_in_ready), 64'd1);
      chk("post_rst_ready2", 64'(o2_in_ready), 64'd1);

      // back-to-back beats 0x11..0x15, latency STAGES
      for (int k = 0; k < 7; k++) begin
         tick();
         if (k < 5) begin
            in_valid = 1'b1;
            in_head  = 8'h11 + 8'(k);
            in_ch_en = 3'b111;
            in_len   = 24'h010203;
            in_msg   = 48'h1;
            in_etx   = 8'hE0;
         end else begin
            in_valid = 1'b0;
         end
         probe();
         chk("b2b_ready", 64'(o1_in_ready), 64'd1);
         chk("b2b_valid_s1", 64'(o1_out_valid), 64'((k >= 1) && (k <= 5)));
         if (k >= 1 && k <= 5) chk("b2b_head_s1", 64'(o1_head), 64'(8'h11 + 8'(k - 1)));
         chk("b2b_valid_s2", 64'(o2_out_valid), 64'((k >= 2) && (k <= 6)));
         if (k >= 2) chk("b2b_head_s2", 64'(o2_head), 64'(8'h11 + 8'(k - 2)));
      end

      // channel masking table
      for (int i = 0; i < 6; i++) begin
         tick();
         in_valid = 1'b1;
         in_ch_en = vecs[i].ch_en;
         in_len   = vecs[i].len;
         in_msg   = vecs[i].msg;
         in_head  = 8'h40 + 8'(i);
         in_etx   = 8'h80 + 8'(i);
         tick();
         in_valid = 1'b0;
         in_len   = '1;
         in_msg   = '1;
         probe();
         chk("vec_valid", 64'(o1_out_valid), 64'd1);
         chk("vec_ch_en", 64'(o1_ch_en), 64'(vecs[i].ch_en));
         chk("vec_len", 64'(o1_len), 64'(vecs[i].exp_len));
         chk("vec_msg", 64'(o1_msg), 64'(vecs[i].exp_msg));
         chk("vec_head", 64'(o1_head), 64'(8'h40 + 8'(i)));
         chk("vec_etx", 64'(o1_etx), 64'(8'h80 + 8'(i)));
      end
      repeat (3) tick();

      // capacity with downstream stalled
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ch_en  = 3'b111;
      in_head   = 8'h21;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         probe();
         took = o2_in_ready;
         if (took) acc++;
         tick();
         if (took) in_head = in_head + 8'd1;
      end
      in_valid = 1'b0;
      probe();
      chk("cap_accepted", 64'(acc), 64'd4);
      chk("cap_ready2_low", 64'(o2_in_ready), 64'd0);
      chk("cap_ready1_low", 64'(o1_in_ready), 64'd0);
      chk("stall_valid", 64'(o2_out_valid), 64'd1);
      chk("stall_head", 64'(o2_head), 64'h21);
      tick();
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         probe();
         chk("drain_valid", 64'(o2_out_valid), 64'd1);
         chk("drain_head", 64'(o2_head), 64'(8'h21 + 8'(j)));
         tick();
      end
      probe();
      chk("drain_empty", 64'(o2_out_valid), 64'd0);
      repeat (3) tick();

      // flush with beats buffered and a beat offered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int j = 0; j < 3; j++) begin
         in_head = 8'h31 + 8'(j);
         probe();
         chk("fl_fill_ready", 64'(o2_in_ready), 64'd1);
         tick();
      end
      flush   = 1'b1;
      in_head = 8'h3F;
      probe();
      chk("fl_ready2_during", 64'(o2_in_ready), 64'd0);
      chk("fl_ready1_during", 64'(o1_in_ready), 64'd0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      probe();
      chk("fl_valid_after", 64'(o2_out_valid), 64'd0);
      chk("fl_ready_after", 64'(o2_in_ready), 64'd0);
      tick();
      in_valid  = 1'b1;
      in_head   = 8'h50;
      out_ready = 1'b1;
      probe();
      chk("fl_ready_reopen", 64'(o2_in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      seen = 0;
      for (int j = 0; j < 6; j++) begin
         probe();
         if (o2_out_valid) begin
            seen++;
            chk("fl_post_head", 64'(o2_head), 64'h50);
         end
         tick();
      end
      chk("fl_post_count", 64'(seen), 64'd1);

      // counters: 7 stall cycles then 4 transfers
      rst       = 1'b1;
      out_ready = 1'b0;
      probe();
      chk("rst2_out_valid", 64'(o2_out_valid), 64'd0);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 13; c++) begin
         in_valid  = (c < 4);
         in_head   = 8'h61 + 8'(c);
         out_ready = (c >= 9);
         probe();
         if (c < 4) chk("cnt_fill_ready", 64'(o2_in_ready), 64'd1);
         if (c == 2) chk("cnt_first_valid", 64'(o2_out_valid), 64'd1);
         if (c >= 9) chk("cnt_out_head", 64'(o2_head), 64'(8'h61 + 8'(c - 9)));
         tick();
      end
      probe();
      chk("cnt_stall", 64'(o2_stall), 64'(EXP_STALL));
      chk("cnt_beat", 64'(o2_beat), 64'(EXP_BEAT));
      chk("cnt_end_valid", 64'(o2_out_valid), 64'd0);

      // reset mid-stream discards in-flight beats
      tick();
      in_valid  = 1'b1;
      in_head   = 8'h71;
      out_ready = 1'b0;
      tick();
      in_head = 8'h72;
      tick();
      in_head = 8'h73;
      rst = 1'b1;
      probe();
      chk("mid_rst_ready", 64'(o2_in_ready), 64'd0);
      chk("mid_rst_valid", 64'(o2_out_valid), 64'd0);
      tick();
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      probe();
      chk("mid_rst_stall", 64'(o2_stall), 64'd0);
      chk("mid_rst_beat", 64'(o2_beat), 64'd0);
      chk("mid_rst_head", 64'(o2_head), 64'd0);
      chk("mid_rst_ready_after", 64'(o2_in_ready), 64'd1);
      seen = 0;
      for (int j = 0; j < 4; j++) begin
         probe();
         if (o2_out_valid) seen++;
         tick();
      end
      chk("mid_rst_nothing_out", 64'(seen), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
